// File: rtl/td4_pkg.sv
// Shared opcodes, ALU-source encodings, load-enable bit indices and the decoded control word.
// Optional illegal-opcode trap is controlled by TD4_ILLEGAL_TRAP_EN (see td4_decode_comb/td4_decode_stage).
package td4_pkg;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_A   = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_B   = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_IM  = 4'b1011;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam int LOAD_A   = 0;
    localparam int LOAD_B   = 1;
    localparam int LOAD_OUT = 2;
    localparam int LOAD_PC  = 3;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] load;
        logic       is_add;
        logic       illegal;
    } td4_ctrl_t;

endpackage

// File: rtl/td4_decode_comb.sv
// Pure combinational TD4 opcode table: opcode + effective carry -> sel, load, is_add, illegal.
// illegal is only ever raised when TD4_ILLEGAL_TRAP_EN is defined.
module td4_decode_comb
    import td4_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       carry,
    output logic [1:0] sel,
    output logic [3:0] load,
    output logic       is_add,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_ZERO;
        load    = '0;
        is_add  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD_A:   begin sel = SEL_A;  load[LOAD_A] = 1'b1; is_add = 1'b1; end
            OP_ADD_B:   begin sel = SEL_B;  load[LOAD_B] = 1'b1; is_add = 1'b1; end
            OP_MOV_A:   begin load[LOAD_A] = 1'b1; end
            OP_MOV_B:   begin load[LOAD_B] = 1'b1; end
            OP_MOV_A_B: begin sel = SEL_B;  load[LOAD_A] = 1'b1; end
            OP_MOV_B_A: begin sel = SEL_A;  load[LOAD_B] = 1'b1; end
            OP_IN_A:    begin sel = SEL_IN; load[LOAD_A] = 1'b1; end
            OP_IN_B:    begin sel = SEL_IN; load[LOAD_B] = 1'b1; end
            OP_OUT_B:   begin sel = SEL_B;  load[LOAD_OUT] = 1'b1; end
            OP_OUT_IM:  begin load[LOAD_OUT] = 1'b1; end
            OP_JMP:     begin load[LOAD_PC] = 1'b1; end
            OP_JNC:     begin load[LOAD_PC] = !carry; end
            default: begin
`ifdef TD4_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/td4_decode_stage.sv
// Registered TD4 decode stage with valid/ready handshake, carry register and pending-ADD tracking.
// TD4_ILLEGAL_TRAP_EN: unlisted opcodes raise illegal and lock in_ready low until rst.
module td4_decode_stage
    import td4_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int MAX_PEND = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W+3:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_sel,
    output logic [3:0]        out_load,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_is_add,
    input  logic              carry_valid,
    input  logic              carry_in,
    output logic              carry_flag,
    output logic              proto_err,
    output logic              illegal
);

    localparam int PEND_W = 3;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic              carry_eff;
    logic [1:0]        dec_sel;
    logic [3:0]        dec_load;
    logic              dec_is_add;
    logic              dec_illegal;
    td4_ctrl_t         dec;

    logic              out_valid_q, out_valid_d;
    td4_ctrl_t         ctrl_q, ctrl_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              carry_flag_q, carry_flag_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              proto_err_q, proto_err_d;
    logic              trap_q;

    logic              ret_ok;
    logic [PEND_W-1:0] pend_after_ret;
    logic              stall;
    logic              ready_c;
    logic              accept;

    assign opcode = in_instr[DATA_W+3 -: 4];
    assign imm    = in_instr[DATA_W-1:0];

    // A carry returning this cycle is bypassed straight into the JNC decision.
    assign carry_eff = carry_valid ? carry_in : carry_flag_q;

    td4_decode_comb u_decode (
        .opcode  (opcode),
        .carry   (carry_eff),
        .sel     (dec_sel),
        .load    (dec_load),
        .is_add  (dec_is_add),
        .illegal (dec_illegal)
    );

    assign dec = '{sel: dec_sel, load: dec_load, is_add: dec_is_add, illegal: dec_illegal};

    always_comb begin
        ret_ok         = carry_valid && (pend_q != '0);
        pend_after_ret = pend_q - PEND_W'(ret_ok);
        stall          = ((opcode == OP_JNC) && (pend_after_ret != '0))
                       || (dec.is_add && (pend_q == PEND_MAX) && !carry_valid);
        ready_c        = (!out_valid_q || out_ready) && !stall && !trap_q;
        accept         = in_valid && ready_c;

        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        imm_d       = imm_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            imm_d       = imm;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        pend_d       = pend_after_ret + PEND_W'(accept && dec.is_add);
        carry_flag_d = carry_valid ? carry_in : carry_flag_q;
        proto_err_d  = proto_err_q || (carry_valid && (pend_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            ctrl_q       <= '{sel: SEL_A, load: 4'b0000, is_add: 1'b0, illegal: 1'b0};
            imm_q        <= '0;
            carry_flag_q <= 1'b0;
            pend_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            ctrl_q       <= ctrl_d;
            imm_q        <= imm_d;
            carry_flag_q <= carry_flag_d;
            pend_q       <= pend_d;
            proto_err_q  <= proto_err_d;
        end
    end

`ifdef TD4_ILLEGAL_TRAP_EN
    logic trap_d;

    assign trap_d = trap_q || (accept && dec.illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`else
    assign trap_q = 1'b0;
`endif

    assign in_ready   = ready_c;
    assign out_valid  = out_valid_q;
    assign out_sel    = ctrl_q.sel;
    assign out_load   = ctrl_q.load;
    assign out_imm    = imm_q;
    assign out_is_add = ctrl_q.is_add;
    assign carry_flag = carry_flag_q;
    assign proto_err  = proto_err_q;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_td4_decode_stage.sv
// Bench for td4_decode_stage: directed scenarios plus randomized traffic against a table-driven model.
// Follows TD4_ILLEGAL_TRAP_EN to know whether unlisted opcodes trap.
module tb_td4_decode_stage;

    localparam int DATA_W   = 4;
    localparam int MAX_PEND = 2;
`ifdef TD4_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk, rst;
    logic       in_valid, in_ready;
    logic [7:0] in_instr;
    logic       out_valid, out_ready;
    logic [1:0] out_sel;
    logic [3:0] out_load;
    logic [3:0] out_imm;
    logic       out_is_add;
    logic       carry_valid, carry_in;
    logic       carry_flag, proto_err, illegal;

    td4_decode_stage #(.DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .out_load(out_load), .out_imm(out_imm), .out_is_add(out_is_add),
        .carry_valid(carry_valid), .carry_in(carry_in),
        .carry_flag(carry_flag), .proto_err(proto_err), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // model state
    bit       m_ov, m_add, m_ill, m_carry, m_proto, m_trap;
    bit [1:0] m_sel;
    bit [3:0] m_load, m_imm;
    int       m_pend;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // {legal, is_add, sel[1:0], load[3:0]} straight from the instruction table; JNC load patched by caller
    function automatic logic [7:0] spec_row(input logic [3:0] op);
        case (op)
            4'b0000: return {1'b1, 1'b1, 2'b00, 4'b0001};
            4'b0101: return {1'b1, 1'b1, 2'b01, 4'b0010};
            4'b0011: return {1'b1, 1'b0, 2'b11, 4'b0001};
            4'b0111: return {1'b1, 1'b0, 2'b11, 4'b0010};
            4'b0001: return {1'b1, 1'b0, 2'b01, 4'b0001};
            4'b0100: return {1'b1, 1'b0, 2'b00, 4'b0010};
            4'b0010: return {1'b1, 1'b0, 2'b10, 4'b0001};
            4'b0110: return {1'b1, 1'b0, 2'b10, 4'b0010};
            4'b1001: return {1'b1, 1'b0, 2'b01, 4'b0100};
            4'b1011: return {1'b1, 1'b0, 2'b11, 4'b0100};
            4'b1111: return {1'b1, 1'b0, 2'b11, 4'b1000};
            4'b1110: return {1'b1, 1'b0, 2'b11, 4'b1000};
            default: return {1'b0, 1'b0, 2'b11, 4'b0000};
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 0; m_add = 0; m_ill = 0; m_carry = 0; m_proto = 0; m_trap = 0;
        m_sel = 0; m_load = 0; m_imm = 0; m_pend = 0;
    endtask

    // One clock: drive inputs, compare DUT against the model, then advance the model.
    task automatic step(input logic v, input logic [7:0] ins, input logic ordy,
                        input logic cv, input logic cin);
        logic [7:0] row;
        logic [3:0] op;
        logic       er, acc, ceff;
        int         after;
        @(posedge clk);
        #1;
        in_valid = v; in_instr = ins; out_ready = ordy; carry_valid = cv; carry_in = cin;
        #1;
        op    = ins[7:4];
        row   = spec_row(op);
        after = m_pend - ((cv && m_pend > 0) ? 1 : 0);
        er    = (!m_ov || ordy) && !m_trap
              && !((op == 4'b1110 && after != 0) || (row[6] && m_pend == MAX_PEND && !cv));
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, m_ov);
        chk("carry_flag", carry_flag, m_carry);
        chk("proto_err", proto_err, m_proto);
        if (m_ov) begin
            chk("out_sel", out_sel, m_sel);
            chk("out_load", out_load, m_load);
            chk("out_imm", out_imm, m_imm);
            chk("out_is_add", out_is_add, m_add);
            chk("illegal", illegal, m_ill);
        end
        acc  = v && er;
        ceff = cv ? cin : m_carry;
        if (acc) begin
            m_ov   = 1;
            m_sel  = row[5:4];
            m_load = (op == 4'b1110) ? (ceff ? 4'b0000 : 4'b1000) : row[3:0];
            m_imm  = ins[3:0];
            m_add  = row[6];
            m_ill  = TRAP && !row[7];
            if (m_ill) m_trap = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (cv) begin
            if (m_pend == 0) m_proto = 1;
            else m_pend--;
            m_carry = cin;
        end
        if (acc && row[6]) m_pend++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 0; in_instr = 0; out_ready = 0; carry_valid = 0; carry_in = 0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_instr = 0; out_ready = 0; carry_valid = 0; carry_in = 0;
        model_reset();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_load", out_load, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // MOV A,3
        step(1, 8'h33, 1, 0, 0);
        chk("mov_ready", in_ready, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("mov_valid", out_valid, 1);
        chk("mov_sel", out_sel, 2'b11);
        chk("mov_load", out_load, 4'b0001);
        chk("mov_imm", out_imm, 3);

        // ADD then JNC, carry returns 0 in the same cycle
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'hE5, 1, 0, 0);
        chk("jnc_stall", in_ready, 0);
        step(1, 8'hE5, 1, 1, 0);
        chk("jnc_bypass_ready", in_ready, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("jnc_c0_load", out_load, 4'b1000);
        chk("jnc_c0_imm", out_imm, 5);

        // same with carry 1
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'hE5, 1, 0, 0);
        chk("jnc_stall2", in_ready, 0);
        step(1, 8'hE5, 1, 1, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("jnc_c1_load", out_load, 4'b0000);
        chk("jnc_c1_carry", carry_flag, 1);

        // three ADDs, third stalls until a carry returns
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h01, 1, 0, 0);
        chk("max_pend_stall", in_ready, 0);
        step(1, 8'h01, 1, 1, 0);
        chk("max_pend_release", in_ready, 1);
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 1, 1, 0);

        // back-pressure hold on MOV B,A
        step(1, 8'h40, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 8'h72, 0, 0, 0);
            chk("hold_ready", in_ready, 0);
            chk("hold_sel", out_sel, 2'b00);
            chk("hold_load", out_load, 4'b0010);
        end
        step(1, 8'h72, 1, 0, 0);
        chk("release_ready", in_ready, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("next_sel", out_sel, 2'b11);
        chk("next_load", out_load, 4'b0010);
        chk("next_imm", out_imm, 2);

        // stray carry return
        step(0, 8'h00, 1, 1, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("proto_set", proto_err, 1);
        step(0, 8'h00, 1, 0, 0);
        chk("proto_sticky", proto_err, 1);

        // asynchronous reset mid-cycle
        step(1, 8'h33, 1, 0, 0);
        @(posedge clk);
        #3;
        chk("pre_arst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_proto", proto_err, 0);
        chk("arst_carry", carry_flag, 0);
        chk("arst_load", out_load, 0);
        in_valid = 0; in_instr = 0; out_ready = 0; carry_valid = 0; carry_in = 0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // unlisted opcode 1000
        step(1, 8'h87, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        chk("ill_flag", illegal, TRAP);
        chk("ill_load", out_load, 0);
        chk("ill_sel", out_sel, 2'b11);
        step(1, 8'h33, 1, 0, 0);
        chk("ill_after_ready", in_ready, !TRAP);
        step(0, 8'h00, 1, 0, 0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, ordy, cv, cin;
            logic [7:0] ins;
            if (i % 250 == 249) do_reset();
            v    = ($urandom % 4) != 0;
            ins  = 8'($urandom);
            ordy = ($urandom % 4) != 0;
            cv   = (m_pend > 0) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
            cin  = 1'($urandom);
            step(v, ins, ordy, cv, cin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
